// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_unit
//  Description : Instruction fetch front end. Owns the fetch PC, issues
//                single-word reads to a synchronous instruction memory,
//                latches the returned word into allBits and offers it to the
//                controller over a valid/ready handshake. Handles jump/branch
//                redirects and a halt request.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter int ADDR_W   = 12,
    parameter int INSTR_W  = 19,
    parameter int RESET_PC = 0
) (
    input  logic               clk,
    input  logic               rst,
    // Instruction memory read port
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    // Controller interface
    output logic [INSTR_W-1:0] allBits,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [ADDR_W-1:0]  pc_out,
    output logic [ADDR_W-1:0]  pc_next,
    // Control flow
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_target,
    input  logic               halt,
    output logic               halted
);

    localparam logic [ADDR_W-1:0] c_reset_pc = RESET_PC[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] c_pc_one   = {{(ADDR_W-1){1'b0}}, 1'b1};

    // REQ   : address on the bus, request asserted (unless halting)
    // WAIT  : memory returns the word at the next edge
    // HOLD  : word presented to the controller until accepted
    // HALTED: idle until a redirect restarts fetching
    typedef enum logic [1:0] {
        ST_REQ    = 2'd0,
        ST_WAIT   = 2'd1,
        ST_HOLD   = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    state_t               state_q,    state_d;
    logic [ADDR_W-1:0]    fetch_pc_q, fetch_pc_d;
    logic [INSTR_W-1:0]   bits_q,     bits_d;
    logic [ADDR_W-1:0]    pc_out_q,   pc_out_d;

    // Next-state and request logic; redirect takes priority over everything
    // except reset, including halt and a completing handshake.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        bits_d     = bits_q;
        pc_out_d   = pc_out_q;
        imem_req   = 1'b0;

        case (state_q)
            ST_REQ: begin
                // A pending halt suppresses the read so memory sees no access.
                imem_req = ~halt;
                if (redirect) begin
                    fetch_pc_d = redirect_target;
                    state_d    = ST_REQ;
                end else if (halt) begin
                    state_d = ST_HALTED;
                end else begin
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (redirect) begin
                    // Returning word belongs to the old path: drop it.
                    fetch_pc_d = redirect_target;
                    state_d    = ST_REQ;
                end else begin
                    bits_d     = imem_data;
                    pc_out_d   = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + c_pc_one;
                    state_d    = ST_HOLD;
                end
            end

            ST_HOLD: begin
                if (redirect) begin
                    // Accepted or squashed, the held word is retired either way.
                    fetch_pc_d = redirect_target;
                    state_d    = ST_REQ;
                end else if (instr_ready) begin
                    state_d = halt ? ST_HALTED : ST_REQ;
                end
            end

            ST_HALTED: begin
                if (redirect) begin
                    fetch_pc_d = redirect_target;
                    state_d    = ST_REQ;
                end
            end

            default: begin
                state_d = ST_REQ;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_REQ;
            fetch_pc_q <= c_reset_pc;
            bits_q     <= '0;
            pc_out_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            bits_q     <= bits_d;
            pc_out_q   <= pc_out_d;
        end
    end

    // Status and datapath outputs are decoded straight from registered state.
    assign instr_valid = (state_q == ST_HOLD);
    assign halted      = (state_q == ST_HALTED);
    assign imem_addr   = fetch_pc_q;
    assign allBits     = bits_q;
    assign pc_out      = pc_out_q;
    assign pc_next     = pc_out_q + c_pc_one;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch_unit
//  Description : Self-checking bench for instr_fetch_unit: directed vector
//                table, hand-written corner sequences and a randomized run
//                against a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    localparam int AW = 12;
    localparam int IW = 19;

    logic          clk;
    logic          rst;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic [IW-1:0] imem_data;
    logic [IW-1:0] allBits;
    logic          instr_valid;
    logic          instr_ready;
    logic [AW-1:0] pc_out;
    logic [AW-1:0] pc_next;
    logic          redirect;
    logic [AW-1:0] redirect_target;
    logic          halt;
    logic          halted;

    int checks = 0;
    int errors = 0;

    instr_fetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .RESET_PC(0)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_data       (imem_data),
        .allBits         (allBits),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .pc_out          (pc_out),
        .pc_next         (pc_next),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .halt            (halt),
        .halted          (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory: word for a request appears one cycle later; with no
    // request the bus carries junk so a misplaced latch is visible.
    logic [IW-1:0] mem [4096];
    always @(posedge clk) begin
        if (imem_req) imem_data <= mem[imem_addr];
        else          imem_data <= IW'($urandom);
    end

    // ------------------------------------------------------------------
    // Reference model: what the controller should see, tracked as
    // "request in flight", "word held", "halted" and a fetch pointer.
    // ------------------------------------------------------------------
    bit            m_known = 0;
    bit            m_busy, m_hold, m_halt;
    logic [AW-1:0] m_pc, m_pcout;
    logic [IW-1:0] m_bits;

    task automatic model_update();
        if (rst) begin
            m_known = 1; m_busy = 0; m_hold = 0; m_halt = 0;
            m_pc = '0; m_pcout = '0; m_bits = '0;
        end else if (m_halt) begin
            if (redirect) begin m_halt = 0; m_pc = redirect_target; end
        end else if (m_hold) begin
            if (redirect) begin m_hold = 0; m_pc = redirect_target; end
            else if (instr_ready) begin m_hold = 0; m_halt = halt; end
        end else if (m_busy) begin
            m_busy = 0;
            if (redirect) m_pc = redirect_target;
            else begin
                m_bits = mem[m_pc]; m_pcout = m_pc; m_pc = m_pc + 1'b1; m_hold = 1;
            end
        end else begin
            if (redirect)  m_pc = redirect_target;
            else if (halt) m_halt = 1;
            else           m_busy = 1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        logic [AW-1:0] nxt;
        if (!m_known) return;
        nxt = m_pcout + 1'b1;
        chk("m_req",    32'(imem_req),    32'(!m_busy && !m_hold && !m_halt && !halt));
        chk("m_addr",   32'(imem_addr),   32'(m_pc));
        chk("m_valid",  32'(instr_valid), 32'(m_hold));
        chk("m_bits",   32'(allBits),     32'(m_bits));
        chk("m_pcout",  32'(pc_out),      32'(m_pcout));
        chk("m_pcnext", 32'(pc_next),     32'(nxt));
        chk("m_halted", 32'(halted),      32'(m_halt));
    endtask

    // One clock: compare at the falling edge, advance the model at the rising
    // edge, then leave 1 time unit for the DUT outputs to settle.
    task automatic step();
        @(negedge clk);
        model_check();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drive(input bit r, input bit rdy, input bit red,
                         input logic [AW-1:0] tgt, input bit h);
        rst = r; instr_ready = rdy; redirect = red; redirect_target = tgt; halt = h;
    endtask

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct {
        bit            rst, rdy, red;
        logic [AW-1:0] tgt;
        bit            chk;
        bit            e_req;
        logic [AW-1:0] e_addr;
        bit            e_valid;
        logic [IW-1:0] e_bits;
        logic [AW-1:0] e_pcout;
    } vec_t;

    vec_t tv[$];

    task automatic add(input bit r, input bit rdy, input bit red, input logic [AW-1:0] tgt,
                       input bit c, input bit req, input logic [AW-1:0] addr,
                       input bit v, input logic [IW-1:0] b, input logic [AW-1:0] pco);
        vec_t e;
        e.rst = r; e.rdy = rdy; e.red = red; e.tgt = tgt; e.chk = c;
        e.e_req = req; e.e_addr = addr; e.e_valid = v; e.e_bits = b; e.e_pcout = pco;
        tv.push_back(e);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = IW'($urandom);
        mem[12'h000] = 19'h04AC0;
        mem[12'h001] = 19'h3FC10;
        mem[12'h002] = 19'h12345;
        mem[12'h100] = 19'h2A5A5;
        drive(1, 1, 0, '0, 0);

        // reset, sequential fetch
        add(1,1,0,12'h000, 0, 0,12'h000,0,19'h00000,12'h000);
        add(0,1,0,12'h000, 1, 1,12'h000,0,19'h00000,12'h000);
        add(0,1,0,12'h000, 1, 0,12'h000,0,19'h00000,12'h000);
        add(0,1,0,12'h000, 1, 0,12'h001,1,19'h04AC0,12'h000);
        add(0,1,0,12'h000, 1, 1,12'h001,0,19'h04AC0,12'h000);
        add(0,1,0,12'h000, 1, 0,12'h001,0,19'h04AC0,12'h000);
        add(0,1,0,12'h000, 1, 0,12'h002,1,19'h3FC10,12'h001);
        add(0,1,0,12'h000, 1, 1,12'h002,0,19'h3FC10,12'h001);
        add(0,1,0,12'h000, 1, 0,12'h002,0,19'h3FC10,12'h001);
        // backpressure: 5 cycles of ready low in HOLD
        for (int i = 0; i < 5; i++)
            add(0,0,0,12'h000, 1, 0,12'h003,1,19'h12345,12'h002);
        add(0,1,0,12'h000, 1, 0,12'h003,1,19'h12345,12'h002);
        add(0,1,0,12'h000, 1, 1,12'h003,0,19'h12345,12'h002);
        // redirect in WAIT
        add(0,1,1,12'h100, 1, 0,12'h003,0,19'h12345,12'h002);
        add(0,1,0,12'h000, 1, 1,12'h100,0,19'h12345,12'h002);
        add(0,1,0,12'h000, 1, 0,12'h100,0,19'h12345,12'h002);
        // redirect together with accept in HOLD
        add(0,1,1,12'h020, 1, 0,12'h101,1,19'h2A5A5,12'h100);
        add(0,1,0,12'h000, 1, 1,12'h020,0,19'h2A5A5,12'h100);

        foreach (tv[i]) begin
            drive(tv[i].rst, tv[i].rdy, tv[i].red, tv[i].tgt, 0);
            @(negedge clk);
            if (tv[i].chk) begin
                chk("t_req",   32'(imem_req),    32'(tv[i].e_req));
                chk("t_addr",  32'(imem_addr),   32'(tv[i].e_addr));
                chk("t_valid", 32'(instr_valid), 32'(tv[i].e_valid));
                chk("t_bits",  32'(allBits),     32'(tv[i].e_bits));
                chk("t_pcout", 32'(pc_out),      32'(tv[i].e_pcout));
                chk("t_halt",  32'(halted),      32'(0));
            end
            model_check();
            @(posedge clk);
            model_update();
            #1;
        end

        // Wrap at the top of the address space, then halt at handshake.
        drive(0, 0, 1, 12'hFFF, 0); step();
        drive(0, 0, 0, 12'h000, 0); step(); step();
        drive(0, 1, 0, 12'h000, 1); #1;
        chk("wrap_valid",  32'(instr_valid), 32'(1));
        chk("wrap_pcout",  32'(pc_out),      32'(12'hFFF));
        chk("wrap_addr",   32'(imem_addr),   32'(12'h000));
        chk("wrap_pcnext", 32'(pc_next),     32'(12'h000));
        step();
        for (int i = 0; i < 4; i++) begin
            drive(0, i[0], 0, 12'h000, i[1]); #1;
            chk("halt_flag", 32'(halted),      32'(1));
            chk("halt_req",  32'(imem_req),    32'(0));
            chk("halt_val",  32'(instr_valid), 32'(0));
            step();
        end
        drive(0, 1, 1, 12'h005, 1); step();
        drive(0, 1, 0, 12'h000, 0); #1;
        chk("resume_halted", 32'(halted),    32'(0));
        chk("resume_addr",   32'(imem_addr), 32'(12'h005));
        chk("resume_req",    32'(imem_req),  32'(1));
        step(); step();
        drive(0, 0, 0, 12'h000, 0); #1;
        chk("resume_pcout", 32'(pc_out), 32'(12'h005));
        chk("resume_bits",  32'(allBits), 32'(mem[12'h005]));

        // Reset while holding a valid word.
        step();
        drive(1, 0, 0, 12'h000, 0); step();
        drive(0, 0, 0, 12'h000, 0); #1;
        chk("rst_valid", 32'(instr_valid), 32'(0));
        chk("rst_bits",  32'(allBits),     32'(0));
        chk("rst_addr",  32'(imem_addr),   32'(0));
        chk("rst_req",   32'(imem_req),    32'(1));
        chk("rst_pcout", 32'(pc_out),      32'(0));
        step();

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            drive(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 9) == 0),
                  (($urandom_range(0, 3) == 0) ? 12'hFFE : AW'($urandom)),
                  ($urandom_range(0, 7) == 0));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Producer end of the 19-bit instruction interface consumed by the controller. Owns the fetch PC and issues read requests to a synchronous instruction memory. Latches the returned word into the allBits register and presents it to the controller with a valid/ready handshake. Handles control-flow redirects (jump/branch) from the datapath and a halt request.

Parameters:
ADDR_W, 12, width of instruction-memory address and PC
INSTR_W, 19, instruction word width (matches controller allBits)
RESET_PC, 0, fetch address after reset

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
imem_req  output  1  read request to instruction memory (combinational from state)
imem_addr  output  ADDR_W  read address, equals fetch_pc
imem_data  input  INSTR_W  read data, valid exactly one cycle after imem_req
allBits  output  INSTR_W  registered instruction word presented to controller
instr_valid  output  1  allBits holds an instruction not yet accepted
instr_ready  input  1  controller accepts allBits this cycle
pc_out  output  ADDR_W  address of the instruction in allBits
pc_next  output  ADDR_W  pc_out + 1 mod 2^ADDR_W (link/relative base)
redirect  input  1  control-flow change request
redirect_target  input  ADDR_W  new fetch address
halt  input  1  stop fetching after current instruction
halted  output  1  unit is in HALTED state

Behaviour:
- Reset (rst=1 at edge): fetch_pc=RESET_PC, state=REQ, allBits=0, instr_valid=0, pc_out=0, halted=0. rst overrides every other input.
- States: REQ, WAIT, HOLD, HALTED.
- REQ: imem_req=1, imem_addr=fetch_pc. Next state WAIT.
- WAIT: imem_req=0. At edge: allBits<=imem_data, pc_out<=fetch_pc, fetch_pc<=fetch_pc+1 (wraps 2^ADDR_W-1 -> 0), instr_valid<=1. Next state HOLD.
- HOLD: instr_valid=1. allBits, pc_out stable while instr_ready=0, for any number of cycles. When instr_ready=1 at the edge, the handshake completes and instr_valid<=0. Next state is HALTED if halt=1, else REQ.
- Latency: 2 cycles from REQ entry to instr_valid=1. Minimum 3 cycles per instruction with instr_ready held high.
- instr_ready while instr_valid=0 is ignored.
- redirect=1 at an edge, in any non-reset state: fetch_pc<=redirect_target, instr_valid<=0, halted<=0, state<=REQ.
  - In WAIT, the returning imem_data is discarded and allBits is unchanged.
  - In HOLD with instr_ready=1 in the same cycle, the handshake counts as completed (instruction consumed), then the redirect applies.
  - In HOLD with instr_ready=0, the held instruction is squashed.
- halt: sampled only in REQ and at HOLD handshake completion. In REQ with halt=1, no request is issued and the next state is HALTED. halt and redirect in the same cycle: redirect wins.
- HALTED: imem_req=0, instr_valid=0, halted=1, fetch_pc frozen. Exit only via redirect (to REQ) or rst.
- pc_next is combinational: pc_out+1, truncated to ADDR_W.

Test Plan:
- Reset then sequential fetch: rst for 1 cycle; memory holds word 0x04AC0 at address 0 and 0x3FC10 at address 1; instr_ready=1. Expect imem_addr 0 then 1; allBits=0x04AC0 with pc_out=0 and instr_valid high in cycle 3; then 0x3FC10 with pc_out=1 in cycle 6.
- Backpressure: instr_ready=0 for 5 cycles in HOLD. Expect allBits, pc_out and instr_valid stable, and no imem_req. Raise ready: instr_valid drops next cycle and the next fetch is at pc_out+1.
- Redirect in WAIT: redirect=1, target=0x100 during WAIT. Expect old data discarded, allBits unchanged, next imem_addr=0x100, and the next valid instruction has pc_out=0x100.
- Redirect with simultaneous accept in HOLD: ready=1, redirect=1, target=0x020. Expect instr_valid=0 next cycle and the next fetch at 0x020 (not pc_out+1).
- Wrap and halt: fetch at 0xFFF, then next imem_addr=0x000. Assert halt at the handshake: expect halted=1 and imem_req=0 thereafter. redirect to 0x005 resumes fetch at 0x005 with halted=0.
- Reset mid-operation: rst=1 in HOLD with instr_valid=1. Expect next cycle instr_valid=0, allBits=0, and imem_addr=RESET_PC in REQ.
